// File: rtl/ifid_skid_stage.sv
// Valid/ready pipeline stage carrying PC and instruction through a 2-entry skid buffer.
// in_ready is decoded from the state register only; flush injects bubbles; stall_cnt saturates.
module ifid_skid_stage #(
  parameter int unsigned         PC_W      = 32,
  parameter int unsigned         IR_W      = 32,
  parameter logic [IR_W-1:0]     NOP_INSTR = '0,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [IR_W-1:0]  in_ir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [IR_W-1:0]  out_ir,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [IR_W-1:0]  main_ir_q, main_ir_d, skid_ir_q, skid_ir_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire, out_fire;

  // Handshake outputs depend on the state register alone.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign occupancy = 2'(state_q);
  assign out_pc    = main_pc_q;
  assign out_ir    = main_ir_q;
  assign stall_cnt = stall_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_pc_d = main_pc_q;
    main_ir_d = main_ir_q;
    skid_pc_d = skid_pc_q;
    skid_ir_d = skid_ir_q;
    stall_d   = stall_q;

    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end

    // Main register is rewritten with the bubble whenever the stage drains.
    if (flush) begin
      state_d   = EMPTY;
      main_pc_d = '0;
      main_ir_d = NOP_INSTR;
      skid_pc_d = '0;
      skid_ir_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_pc_d = in_pc;
            main_ir_d = in_ir;
            state_d   = ONE;
          end
        end
        ONE: begin
          unique case ({in_fire, out_fire})
            2'b11: begin
              main_pc_d = in_pc;
              main_ir_d = in_ir;
            end
            2'b10: begin
              skid_pc_d = in_pc;
              skid_ir_d = in_ir;
              state_d   = FULL;
            end
            2'b01: begin
              main_pc_d = '0;
              main_ir_d = NOP_INSTR;
              state_d   = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (out_fire) begin
            main_pc_d = skid_pc_q;
            main_ir_d = skid_ir_q;
            skid_pc_d = '0;
            skid_ir_d = NOP_INSTR;
            state_d   = ONE;
          end
        end
        default: begin
          state_d   = EMPTY;
          main_pc_d = '0;
          main_ir_d = NOP_INSTR;
          skid_pc_d = '0;
          skid_ir_d = NOP_INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_pc_q <= '0;
      main_ir_q <= NOP_INSTR;
      skid_pc_q <= '0;
      skid_ir_q <= NOP_INSTR;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      main_pc_q <= main_pc_d;
      main_ir_q <= main_ir_d;
      skid_pc_q <= skid_pc_d;
      skid_ir_q <= skid_ir_d;
      stall_q   <= stall_d;
    end
  end

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage: directed scenarios plus randomized traffic
// checked against a queue-based FIFO model; a second instance uses a 4-bit stall counter.
module tb_ifid_skid_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_ir = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_ir;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_pc, s_out_ir;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {pc, ir}, plus stall counters of both widths.
  logic [63:0] mq[$];
  int          m_cnt  = 0;
  int          m_cnt4 = 0;

  always #5 clk = ~clk;

  ifid_skid_stage #(.PC_W(32), .IR_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  ifid_skid_stage #(.PC_W(32), .IR_W(32), .NOP_INSTR(NOP), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_pc(in_pc), .in_ir(in_ir),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_ir(s_out_ir),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  function automatic logic [31:0] exp_pc();
    return (mq.size() > 0) ? mq[0][63:32] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_ir();
    return (mq.size() > 0) ? mq[0][31:0] : NOP;
  endfunction

  // Apply one cycle of inputs, advance past the edge, and update the model.
  task automatic tick(input logic iv, input logic [31:0] pc, input logic [31:0] ir,
                      input logic ordy, input logic fl);
    bit in_f, out_f;
    in_valid  = iv;
    in_pc     = pc;
    in_ir     = ir;
    out_ready = ordy;
    flush     = fl;
    in_f  = iv && (mq.size() < 2);
    out_f = (mq.size() > 0) && ordy;
    if (mq.size() > 0 && !ordy) begin
      if (m_cnt  < 65535) m_cnt++;
      if (m_cnt4 < 15)    m_cnt4++;
    end
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (out_f) void'(mq.pop_front());
      if (in_f)  mq.push_back({pc, ir});
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_cnt4 = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
        out_pc !== 32'h0 || out_ir !== NOP || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_initial: got v=%0b rdy=%0b occ=%0d pc=%h ir=%h cnt=%0d, want 0 1 0 0 %h 0",
               out_valid, in_ready, occupancy, out_pc, out_ir, stall_cnt, NOP);
    end
    tick(1'b1, 32'h500, 32'hA500, 1'b0, 1'b0);
    tick(1'b1, 32'h504, 32'hA504, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL reset_setup_full: occupancy got %0d want 2", occupancy);
    end
    // Assert reset mid-cycle: outputs must clear without a clock edge.
    #2;
    rst = 1'b1;
    mq.delete();
    m_cnt = 0;
    m_cnt4 = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 ||
        out_pc !== 32'h0 || out_ir !== NOP || stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: got v=%0b rdy=%0b occ=%0d pc=%h ir=%h cnt=%0d, want 0 1 0 0 %h 0",
               out_valid, in_ready, occupancy, out_pc, out_ir, stall_cnt, NOP);
    end
    in_valid = 1'b1; in_pc = 32'h5FF; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_held_ignores_inputs: got v=%0b occ=%0d cnt=%0d want 0 0 0",
               out_valid, occupancy, stall_cnt);
    end
    do_reset();
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, pcs[i], pcs[i] ^ 32'hDEAD_0000, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_ir !== (pcs[i] ^ 32'hDEAD_0000) ||
          occupancy !== 2'd1 || in_ready !== 1'b1 || stall_cnt !== 16'd0) begin
        errors++;
        $display("FAIL stream_%0d: got v=%0b pc=%h ir=%h occ=%0d rdy=%0b cnt=%0d, want 1 %h occ=1 rdy=1 cnt=0",
                 i, out_valid, out_pc, out_ir, occupancy, in_ready, stall_cnt, pcs[i]);
      end
    end
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_ir !== NOP || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%0b pc=%h ir=%h occ=%0d, want 0 0 %h 0",
               out_valid, out_pc, out_ir, occupancy, NOP);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(1'b1, 32'h200, 32'hB200, 1'b0, 1'b0);
    tick(1'b1, 32'h204, 32'hB204, 1'b0, 1'b0);
    tick(1'b1, 32'h208, 32'hB208, 1'b0, 1'b0);
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_pc !== 32'h200 || out_ir !== 32'hB200) begin
      errors++;
      $display("FAIL bp_full: got occ=%0d rdy=%0b pc=%h ir=%h, want 2 0 200 B200",
               occupancy, in_ready, out_pc, out_ir);
    end
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL bp_stall_cnt: got %0d want 2", stall_cnt);
    end
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (out_pc !== 32'h204 || out_ir !== 32'hB204 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got pc=%h ir=%h occ=%0d rdy=%0b, want 204 B204 1 1",
               out_pc, out_ir, occupancy, in_ready);
    end
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ir !== NOP || stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL bp_empty: got v=%0b occ=%0d ir=%h cnt=%0d, want 0 0 %h 2",
               out_valid, occupancy, out_ir, stall_cnt, NOP);
    end
  endtask

  task automatic test_flush();
    do_reset();
    tick(1'b1, 32'h300, 32'hC300, 1'b0, 1'b0);
    tick(1'b1, 32'h304, 32'hC304, 1'b0, 1'b0);
    tick(1'b1, 32'h308, 32'hC308, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_ir !== NOP || out_pc !== 32'h0 || occupancy !== 2'd0 ||
        in_ready !== 1'b1 || stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush_full: got v=%0b pc=%h ir=%h occ=%0d rdy=%0b cnt=%0d, want 0 0 %h 0 1 2",
               out_valid, out_pc, out_ir, occupancy, in_ready, stall_cnt, NOP);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || out_pc === 32'h300 || out_pc === 32'h304 || out_pc === 32'h308) begin
        errors++;
        $display("FAIL flush_no_leak_%0d: got v=%0b pc=%h, want v=0 and no flushed pc",
                 i, out_valid, out_pc);
      end
    end
    // Flush while ONE with simultaneous in_fire and out_fire.
    tick(1'b1, 32'h400, 32'hD400, 1'b0, 1'b0);
    tick(1'b1, 32'h404, 32'hD404, 1'b1, 1'b1);
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL flush_one_fire: got v=%0b occ=%0d pc=%h, want 0 0 0",
               out_valid, occupancy, out_pc);
    end
  endtask

  task automatic test_saturation();
    int want;
    do_reset();
    tick(1'b1, 32'h600, 32'hE600, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      want = (i > 15) ? 15 : i;
      checks++;
      if (s_stall_cnt !== 4'(want) || stall_cnt !== 16'(i) || out_pc !== 32'h600) begin
        errors++;
        $display("FAIL sat_%0d: got cnt4=%0d cnt16=%0d pc=%h, want %0d %0d 600",
                 i, s_stall_cnt, stall_cnt, out_pc, want, i);
      end
    end
  endtask

  task automatic test_random();
    logic        iv, ordy, fl, rdy0;
    logic [31:0] pc;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      pc   = $urandom;
      if ((c % 16) == 0) begin
        // Wiggle out_ready and in_valid mid-cycle: in_ready must not follow.
        out_ready = ordy; in_valid = iv;
        #1;
        rdy0 = in_ready;
        out_ready = ~ordy; in_valid = ~iv;
        #1;
        checks++;
        if (in_ready !== rdy0) begin
          errors++;
          $display("FAIL rand_ready_comb_%0d: in_ready got %0b want %0b", c, in_ready, rdy0);
        end
      end
      tick(iv, pc, ~pc, ordy, fl);
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          occupancy !== 2'(mq.size()) || out_pc !== exp_pc() || out_ir !== exp_ir() ||
          stall_cnt !== 16'(m_cnt) || s_stall_cnt !== 4'(m_cnt4)) begin
        errors++;
        $display("FAIL rand_%0d: got v=%0b rdy=%0b occ=%0d pc=%h ir=%h cnt=%0d cnt4=%0d, want %0b %0b %0d %h %h %0d %0d",
                 c, out_valid, in_ready, occupancy, out_pc, out_ir, stall_cnt, s_stall_cnt,
                 (mq.size() > 0), (mq.size() < 2), mq.size(), exp_pc(), exp_ir(), m_cnt, m_cnt4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
